// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU): restoring division, one quotient
// bit per cycle, result delivered as a single-cycle register-file write pulse.
//
//  state | meaning
//  IDLE  | ready for a new operation
//  CALC  | shifting out quotient bits, one per cycle
//  DONE  | result ready; write pulse issued on the way back to IDLE

module div_unit #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        op,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic [ADDR_W-1:0] rd,
    input  logic              kill,
    output logic              busy,
    output logic              wen,
    output logic [ADDR_W-1:0] waddr,
    output logic [XLEN-1:0]   wdata
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [5:0]      LAST_IT = 6'(XLEN - 1);

    state_t state, state_nxt;

    logic              op_rem;
    logic [ADDR_W-1:0] rd_q;
    logic [XLEN-1:0]   dvd_q;
    logic [XLEN-1:0]   dvs_q;
    logic [XLEN-1:0]   rem_q;
    logic [XLEN-1:0]   quot_q;
    logic [5:0]        cnt_q;
    logic              neg_q;
    logic              neg_r;

    logic              in_signed;
    logic              div_zero;
    logic              ovf;
    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;
    logic [XLEN:0]     shifted;
    logic [XLEN:0]     diff;
    logic              ge;

    logic              wen_d;
    logic              upd_d;
    logic [XLEN-1:0]   result;

    assign in_signed = ~op[0];
    assign div_zero  = (rs2_data == '0);
    assign ovf       = in_signed && (rs1_data == MIN_NEG) && (rs2_data == '1);
    assign abs_a     = (in_signed && rs1_data[XLEN-1]) ? -rs1_data : rs1_data;
    assign abs_b     = (in_signed && rs2_data[XLEN-1]) ? -rs2_data : rs2_data;

    // The partial remainder is always below the divisor, so the shifted value
    // fits in XLEN+1 bits and the top bit of the difference is the borrow.
    assign shifted = {rem_q, dvd_q[XLEN-1]};
    assign diff    = shifted - {1'b0, dvs_q};
    assign ge      = ~diff[XLEN];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = (div_zero || ovf) ? DONE : CALC;
            CALC: begin
                if (kill)                state_nxt = IDLE;
                else if (cnt_q == LAST_IT) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        upd_d  = (state == DONE) && !kill;
        wen_d  = upd_d && (rd_q != '0);
        result = op_rem ? (neg_r ? -rem_q : rem_q)
                        : (neg_q ? -quot_q : quot_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_rem <= 1'b0;
            rd_q   <= '0;
            dvd_q  <= '0;
            dvs_q  <= '0;
            rem_q  <= '0;
            quot_q <= '0;
            cnt_q  <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else if (state == IDLE) begin
            if (in_valid) begin
                op_rem <= op[1];
                rd_q   <= rd;
                cnt_q  <= '0;
                dvd_q  <= abs_a;
                dvs_q  <= abs_b;
                if (div_zero) begin
                    quot_q <= '1;
                    rem_q  <= rs1_data;
                    neg_q  <= 1'b0;
                    neg_r  <= 1'b0;
                end else if (ovf) begin
                    quot_q <= MIN_NEG;
                    rem_q  <= '0;
                    neg_q  <= 1'b0;
                    neg_r  <= 1'b0;
                end else begin
                    quot_q <= '0;
                    rem_q  <= '0;
                    neg_q  <= in_signed && (rs1_data[XLEN-1] ^ rs2_data[XLEN-1]);
                    neg_r  <= in_signed && rs1_data[XLEN-1];
                end
            end
        end else if (state == CALC) begin
            rem_q  <= ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
            quot_q <= {quot_q[XLEN-2:0], ge};
            dvd_q  <= {dvd_q[XLEN-2:0], 1'b0};
            cnt_q  <= cnt_q + 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready <= 1'b1;
            busy     <= 1'b0;
            wen      <= 1'b0;
            waddr    <= '0;
            wdata    <= '0;
        end else begin
            in_ready <= (state_nxt == IDLE);
            busy     <= (state_nxt != IDLE);
            wen      <= wen_d;
            if (upd_d) begin
                waddr <= rd_q;
                wdata <= result;
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: hand-computed quotients/remainders, write-back
// latency, fast paths, rd==0 suppression, and kill/reset aborts.

module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd;
    logic        kill;
    logic        busy;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    int n_chk = 0;
    int n_err = 0;

    int          wen_cnt;
    int          wen_edge;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        rdy32, rdy33, rdy_abort;

    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

    div_unit #(.XLEN(32), .ADDR_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rd       (rd),
        .kill     (kill),
        .busy     (busy),
        .wen      (wen),
        .waddr    (waddr),
        .wdata    (wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // abort_kind: 0 none, 1 kill, 2 rst; abort is sampled at edge abort_at+1
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] r, input int abort_kind, input int abort_at);
        int waited;
        waited = 0;
        while (!in_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
        wen_cnt = 0; wen_edge = -1; wa = '0; wd = '0;
        rdy32 = 1'bx; rdy33 = 1'bx; rdy_abort = 1'bx;
        op = o; rs1_data = a; rs2_data = b; rd = r; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k == abort_at + 1) begin
                if (abort_kind == 1) kill = 1'b1;
                if (abort_kind == 2) rst  = 1'b1;
            end
            @(posedge clk); #1;
            kill = 1'b0;
            rst  = 1'b0;
            if (wen) begin
                wen_cnt++;
                wen_edge = k;
                wa = waddr;
                wd = wdata;
            end
            if (k == 32) rdy32 = in_ready;
            if (k == 33) rdy33 = in_ready;
            if (k == abort_at + 1) rdy_abort = in_ready;
        end
    endtask

    task automatic check_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] r,
                            input int exp_edge, input logic [31:0] exp_data);
        run_op(o, a, b, r, 0, 100);
        check({tag, ".wen_cnt"}, 32'(wen_cnt), 32'd1);
        check({tag, ".latency"}, 32'(wen_edge), 32'(exp_edge));
        check({tag, ".waddr"}, 32'(wa), 32'(r));
        check({tag, ".wdata"}, wd, exp_data);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; kill = 1'b0;
        op = '0; rs1_data = '0; rs2_data = '0; rd = '0;
        @(posedge clk); @(posedge clk); #1;
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.wen", 32'(wen), 32'd0);
        check("rst.waddr", 32'(waddr), 32'd0);
        check("rst.wdata", wdata, 32'd0);
        rst = 1'b0;

        check_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 5'd3, 33, 32'd14);
        check_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 5'd3, 33, 32'd2);
        check_op("div_m7_2",   OP_DIV,  32'hFFFF_FFF9, 32'd2, 5'd5, 33, 32'hFFFF_FFFD);
        check_op("rem_m7_2",   OP_REM,  32'hFFFF_FFF9, 32'd2, 5'd5, 33, 32'hFFFF_FFFF);
        check_op("rem_7_m2",   OP_REM,  32'd7, 32'hFFFF_FFFE, 5'd6, 33, 32'd1);
        check_op("div_7_m2",   OP_DIV,  32'd7, 32'hFFFF_FFFE, 5'd6, 33, 32'hFFFF_FFFD);
        check_op("divu_dz",    OP_DIVU, 32'hDEAD_BEEF, 32'd0, 5'd1, 1, 32'hFFFF_FFFF);
        check_op("remu_dz",    OP_REMU, 32'hDEAD_BEEF, 32'd0, 5'd1, 1, 32'hDEAD_BEEF);
        check_op("div_dz",     OP_DIV,  32'hFFFF_FFF9, 32'd0, 5'd7, 1, 32'hFFFF_FFFF);
        check_op("div_ovf",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 1, 32'h8000_0000);
        check_op("rem_ovf",    OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 1, 32'd0);
        check_op("divu_max",   OP_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd31, 33, 32'hFFFF_FFFF);

        run_op(OP_DIVU, 32'hCAFE_D00D, 32'h10, 5'd0, 0, 100);
        check("rd0.wen_cnt", 32'(wen_cnt), 32'd0);
        check("rd0.ready_e32", 32'(rdy32), 32'd0);
        check("rd0.ready_e33", 32'(rdy33), 32'd1);
        check("rd0.wdata", wdata, 32'h0CAF_ED00);
        check("rd0.waddr", 32'(waddr), 32'd0);

        run_op(OP_DIVU, 32'h8BAD_F00D, 32'd3, 5'd4, 1, 10);
        check("kill.wen_cnt", 32'(wen_cnt), 32'd0);
        check("kill.ready", 32'(rdy_abort), 32'd1);
        check_op("after_kill", OP_DIVU, 32'hB105_F00D, 32'd1, 5'd2, 33, 32'hB105_F00D);

        run_op(OP_DIVU, 32'h8BAD_F00D, 32'd3, 5'd4, 2, 10);
        check("rstab.wen_cnt", 32'(wen_cnt), 32'd0);
        check("rstab.ready", 32'(rdy_abort), 32'd1);
        check_op("after_rst", OP_DIVU, 32'hB105_F00D, 32'd1, 5'd2, 33, 32'hB105_F00D);

        run_op(OP_DIVU, 32'd100, 32'd7, 5'd3, 1, 32);
        check("kill_done.wen_cnt", 32'(wen_cnt), 32'd0);
        check("kill_done.ready", 32'(rdy_abort), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative 32-bit RV32M divider: executes DIV, DIVU, REM and REMU.
- Sits in the execute stage and feeds the register file write port (wen/waddr/wdata) directly.
- Accepts one operation at a time through a valid/ready handshake.
- Produces the result after a fixed multi-cycle latency, as a single-cycle write pulse.

Parameters:
- XLEN, 32, operand and result width; only 32 is supported.
- ADDR_W, 5, destination register address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operation request.
- in_ready  out  1  unit idle and able to accept.
- op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0]).
- rs1_data  in  XLEN  dividend.
- rs2_data  in  XLEN  divisor.
- rd  in  ADDR_W  destination register.
- kill  in  1  abort the in-flight operation (pipeline flush).
- busy  out  1  operation in flight.
- wen  out  1  register write strobe, one cycle.
- waddr  out  ADDR_W  write address.
- wdata  out  XLEN  write data.

Behaviour:
- Reset values: in_ready=1, busy=0, wen=0, waddr=0, wdata=0, state=IDLE. Reset has priority over all other inputs.
- Reset mid-operation: the operation is discarded and no wen is issued.
- All outputs are registered.
- States: IDLE, CALC, DONE.
- IDLE
  - in_ready=1, busy=0.
  - Acceptance: in_valid=1 at an edge (edge E0). The unit latches op, rs1_data, rs2_data and rd, and computes the absolute values for signed ops.
  - Normal case: next state CALC, with the 6-bit iteration counter set to 0.
  - Divisor==0: next state DONE directly.
    - Quotient = 0xFFFFFFFF for DIV and DIVU.
    - Remainder = dividend for REM and REMU.
  - Signed overflow (DIV/REM, dividend 0x80000000, divisor 0xFFFFFFFF): next state DONE directly.
    - Quotient = 0x80000000.
    - Remainder = 0.
- CALC
  - busy=1, in_ready=0.
  - Restoring division, one quotient bit per cycle, MSB first.
  - Each step: shift the remainder left and bring in the next dividend bit. If the shifted remainder ≥ |divisor|, subtract the divisor and set the quotient bit to 1; otherwise the bit is 0.
  - The subtract/compare is done at XLEN+1 bits so it never overflows.
  - After 32 iterations (edges E1..E32), next state DONE.
- Sign fix-up (signed ops only)
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Fix-up is applied when the result is written to wdata.
- DONE
  - wen=1 for exactly one cycle; waddr=latched rd; wdata=quotient or remainder per op.
  - busy=1, in_ready=0.
  - Next edge returns to IDLE and wen returns to 0.
- Latency:
  - Normal operation: wen is high in the cycle after edge E33, i.e. 34 cycles from acceptance to the write-back cycle.
  - Fast paths (divisor zero, overflow): wen is high in the cycle after E1.
- rd==0: the computation runs normally but wen stays 0 in DONE. waddr/wdata still update.
- waddr/wdata hold their last value when wen=0.
- kill
  - Sampled in CALC or DONE; the next state is IDLE and wen=0 at that edge. A kill in DONE masks that cycle's wen.
  - kill in IDLE is ignored.
  - kill and in_valid in the same IDLE cycle: the request is accepted.
- No back-to-back acceptance: the earliest new accept is the edge where the state is IDLE again.
- in_valid while in_ready=0 is ignored; the request is not queued.

Test Plan:
- After rst=1 for 2 edges: in_ready=1, wen=0, wdata=0. Then DIVU 100/7 with rd=3 → wen=1 exactly once, 34 cycles after accept, waddr=3, wdata=14. REMU of the same operands → wdata=2.
- DIV 0xFFFFFFF9 / 2 (-7/2), rd=5 → wdata=0xFFFFFFFD (-3). REM -7/2 → 0xFFFFFFFF (-1). REM 7 / 0xFFFFFFFE (7/-2) → 1.
- DIVU 0xdeadbeef/0, rd=1 → wen 2 cycles after accept, wdata=0xFFFFFFFF. REMU 0xdeadbeef/0 → wdata=0xdeadbeef.
- DIV 0x80000000 / 0xFFFFFFFF → fast path, wdata=0x80000000. REM of the same operands → wdata=0.
- DIVU 0xcafed00d / 0x10 with rd=0 → no wen over 40 cycles, in_ready back to 1 after 34 cycles.
- Mid-operation abort: start DIVU 0x8badf00d/3, then either assert kill for one cycle 10 cycles later or pulse rst 10 cycles later.
  - Either way: no wen for that operation, and in_ready=1 the cycle after the abort.
  - A following DIVU 0xb105f00d/1 with rd=2 → wdata=0xb105f00d.
